// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder/subtractor controller: LSB-first through a single full adder.
// Optional subtraction is enabled by defining SERIAL_SUB_EN.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, b_load;
    logic             carry, carry_init;
    logic [CNT_W-1:0] bit_cnt;
    logic             fa_sum, fa_cout;
    logic             load, step, last_step;

`ifdef SERIAL_SUB_EN
    // Two's-complement subtraction: invert B and inject a carry of one.
    assign b_load     = sub ? ~op_b : op_b;
    assign carry_init = sub;
`else
    logic sub_unused;
    assign sub_unused = sub;
    assign b_load     = op_b;
    assign carry_init = 1'b0;
`endif

    assign last_step = (bit_cnt == CNT_W'(WIDTH - 1));

    full_adder u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_step) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            result  <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (load) begin
            a_sh    <= op_a;
            b_sh    <= b_load;
            carry   <= carry_init;
            bit_cnt <= '0;
        end else if (step) begin
            result  <= {fa_sum, result[WIDTH-1:1]};
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            carry   <= fa_cout;
            bit_cnt <= bit_cnt + CNT_W'(1);
            // On the MSB step, carry holds the carry into the MSB.
            if (last_step) begin
                cout <= fa_cout;
                ovf  <= carry ^ fa_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: arithmetic reference model plus directed vectors.
// Expectations for sub=1 follow whether SERIAL_SUB_EN is defined.

module tb_serial_adder_ctrl;
    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .sub    (sub),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: busy lasts WIDTH+1 cycles after acceptance; result is plain arithmetic.
    int unsigned  m_cnt = 0;
    logic [W-1:0] m_res = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt  = 0;
            m_res  = '0;
            m_cout = 1'b0;
            m_ovf  = 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                logic [W-1:0] bx;
                logic [W:0]   full;
                logic         cin;
`ifdef SERIAL_SUB_EN
                cin = sub;
`else
                cin = 1'b0;
`endif
                bx     = cin ? ~op_b : op_b;
                full   = {1'b0, op_a} + {1'b0, bx} + {{W{1'b0}}, cin};
                m_res  = full[W-1:0];
                m_cout = full[W];
                m_ovf  = (op_a[W-1] == bx[W-1]) && (m_res[W-1] != op_a[W-1]);
                m_cnt  = W + 1;
            end
        end else begin
            m_cnt--;
        end
    end

    always @(negedge clk) begin
        chk("busy", busy, m_cnt != 0);
        chk("done", done, m_cnt == 1);
        if (m_cnt <= 1) begin
            chk("result", result, m_res);
            chk("cout", cout, m_cout);
            chk("ovf", ovf, m_ovf);
        end
    end

    // Issue one operation from IDLE, check latency and final values, return in IDLE.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic [W-1:0] er, input logic ec, input logic eo);
        int n;
        bit seen;
        op_a = a; op_b = b; sub = s; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        n = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("latency", seen ? n : -1, 8);
        chk("op_result", result, er);
        chk("op_cout", cout, ec);
        chk("op_ovf", ovf, eo);
        @(posedge clk); #2;
    endtask

    initial begin
        int dn;
        int unsigned last_cyc;
        logic [W-1:0] ha [3];
        logic [W-1:0] hb [3];
        logic [W-1:0] hr [3];
        ha = '{8'd1, 8'd3, 8'd5};
        hb = '{8'd2, 8'd4, 8'd6};
        hr = '{8'd3, 8'd7, 8'd11};

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        @(posedge clk); #2;

        run_op(8'd3,   8'd5, 1'b0, 8'd8,   1'b0, 1'b0);
        run_op(8'd255, 8'd1, 1'b0, 8'd0,   1'b1, 1'b0);
        run_op(8'd127, 8'd1, 1'b0, 8'd128, 1'b0, 1'b1);
        run_op(8'd128, 8'd128, 1'b0, 8'd0, 1'b1, 1'b1);
        run_op(8'd255, 8'd255, 1'b0, 8'd254, 1'b1, 1'b0);

        // Start pulse during RUN at E3 must be ignored.
        op_a = 8'd3; op_b = 8'd5; sub = 1'b0; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (2) @(posedge clk);
        #2 op_a = 8'd100; op_b = 8'd100; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        dn = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                chk("ignore_result", result, 8);
            end
        end
        chk("ignore_done_cnt", dn, 1);
        @(posedge clk); #2;

        // Reset mid-operation, one cycle around E4.
        op_a = 8'd3; op_b = 8'd5; start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_result", result, 0);
        chk("arst_cout_ovf", {cout, ovf}, 0);
        @(posedge clk); #2 rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("arst_no_done", dn, 0);
        @(posedge clk); #2;
        run_op(8'd10, 8'd20, 1'b0, 8'd30, 1'b0, 1'b0);

`ifdef SERIAL_SUB_EN
        run_op(8'd5, 8'd3, 1'b1, 8'd2,   1'b1, 1'b0);
        run_op(8'd3, 8'd5, 1'b1, 8'd254, 1'b0, 1'b0);
`else
        run_op(8'd5, 8'd3, 1'b1, 8'd8,   1'b0, 1'b0);
        run_op(8'd3, 8'd5, 1'b1, 8'd8,   1'b0, 1'b0);
`endif

        // Start held high: back-to-back operations spaced WIDTH+2 cycles.
        sub = 1'b0; op_a = ha[0]; op_b = hb[0]; start = 1'b1;
        dn = 0; last_cyc = 0;
        for (int i = 0; i < 60 && dn < 3; i++) begin
            @(negedge clk);
            if (done) begin
                chk("held_result", result, hr[dn]);
                if (dn > 0) chk("held_spacing", cyc - last_cyc, 10);
                last_cyc = cyc;
                dn++;
                if (dn < 3) begin
                    op_a = ha[dn]; op_b = hb[dn];
                end else begin
                    start = 1'b0;
                end
            end
        end
        chk("held_done_cnt", dn, 3);
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
